// File: rtl/fifo2_arb_pkg.sv
// fifo2_arb_pkg: shared types and constants for the dual-FIFO pop arbiter.
//   arb_state_t   : arbiter FSM state (IDLE, SERVE0, SERVE1)
//   SRC_F0/SRC_F1 : source tags for FIFO 0 / FIFO 1
//   BURST_W       : width of the per-grant burst counter
package fifo2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_t;

  localparam logic SRC_F0 = 1'b0;
  localparam logic SRC_F1 = 1'b1;

  localparam int unsigned BURST_W = 4;

endpackage

// File: rtl/fifo2_arb_burst_cnt.sv
// fifo2_arb_burst_cnt: per-grant burst counter for fifo2_pop_arbiter.
// Ports:
//   clk   in  : clock, rising edge
//   reset in  : synchronous, active-high
//   clr   in  : clear to zero (wins over inc)
//   inc   in  : increment by one
//   term  out : count has reached BURST_MAX-1
module fifo2_arb_burst_cnt
  import fifo2_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [BURST_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + BURST_W'(1);
    end
  end

  assign term = (count == BURST_W'(BURST_MAX - 1));

endmodule

// File: rtl/fifo2_pop_arbiter.sv
// fifo2_pop_arbiter: read-side scheduler for the dual-FIFO stage. Chooses
// which FIFO to pop each cycle (round-robin with BURST_MAX-word bursts),
// never pops an empty FIFO, stalls on downstream almost-full, and merges the
// two FIFO outputs into one registered stream tagged with its source.
// Optional build macro: FIFO2_ARB_STRICT_PRIO_EN -- FIFO 0 gets strict
// priority, rr_last is ignored and BURST_MAX limits only FIFO 1.
// Ports:
//   clk, reset        in  : clock; synchronous active-high reset
//   active            in  : byte-sync lock, pops only while high
//   empty0, empty1    in  : FIFO empty flags
//   data0, data1      in  : FIFO read data, valid the cycle after a pop
//   almost_full_out   in  : downstream almost full, stalls popping
//   pop0, pop1        out : read strobes
//   data_out          out : merged word (holds while valid_out is low)
//   valid_out         out : data_out valid, two cycles after the pop
//   src_out           out : source of data_out (0 = FIFO 0, 1 = FIFO 1)
module fifo2_pop_arbiter
  import fifo2_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              empty0,
  input  logic              empty1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              almost_full_out,
  output logic              pop0,
  output logic              pop1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              src_out
);

  arb_state_t state_q, state_d;
  logic       rr_last, rr_last_d;
  logic       reenter;
  logic       go;
  logic       cnt_clr;
  logic       burst_term;
  logic       pop_d;
  logic       src_d;

  // Reset also gates the strobes so nothing is popped while reset is held.
  assign go   = active & ~almost_full_out & ~reset;
  assign pop0 = (state_q == SERVE0) & ~empty0 & go;
  assign pop1 = (state_q == SERVE1) & ~empty1 & go;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last;
    reenter   = 1'b0;
    case (state_q)
      IDLE: begin
        if (active && !almost_full_out) begin
`ifdef FIFO2_ARB_STRICT_PRIO_EN
          if (!empty0)      state_d = SERVE0;
          else if (!empty1) state_d = SERVE1;
`else
          if (rr_last == SRC_F1) begin
            if (!empty0)      state_d = SERVE0;
            else if (!empty1) state_d = SERVE1;
          end else begin
            if (!empty1)      state_d = SERVE1;
            else if (!empty0) state_d = SERVE0;
          end
`endif
        end
      end
      SERVE0: begin
        if (!active) begin
          state_d = IDLE;
        end else if (!almost_full_out) begin
`ifdef FIFO2_ARB_STRICT_PRIO_EN
          if (empty0) state_d = empty1 ? IDLE : SERVE1;
`else
          if ((pop0 && burst_term) || empty0) begin
            rr_last_d = SRC_F0;
            if (!empty1)      state_d = SERVE1;
            else if (!empty0) reenter = 1'b1;
            else              state_d = IDLE;
          end
`endif
        end
      end
      SERVE1: begin
        if (!active) begin
          state_d = IDLE;
        end else if (!almost_full_out) begin
`ifdef FIFO2_ARB_STRICT_PRIO_EN
          // FIFO 0 refilling ends the grant after the current pop.
          if ((pop1 && burst_term) || empty1 || !empty0) begin
`else
          if ((pop1 && burst_term) || empty1) begin
`endif
            rr_last_d = SRC_F1;
            if (!empty0)      state_d = SERVE0;
            else if (!empty1) reenter = 1'b1;
            else              state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_last <= SRC_F1;
    end else begin
      state_q <= state_d;
      rr_last <= rr_last_d;
    end
  end

  // A re-entered grant restarts its burst without leaving the state.
  assign cnt_clr = (state_d != state_q) || reenter;

  fifo2_arb_burst_cnt #(
    .BURST_MAX(BURST_MAX)
  ) u_burst_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (pop0 | pop1),
    .term (burst_term)
  );

  // Two-stage output pipe: pop -> FIFO data -> registered merged word.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_d     <= 1'b0;
      src_d     <= SRC_F0;
      valid_out <= 1'b0;
      src_out   <= SRC_F0;
      data_out  <= '0;
    end else begin
      pop_d <= pop0 | pop1;
      if (pop0 | pop1) src_d <= pop1 ? SRC_F1 : SRC_F0;
      valid_out <= pop_d;
      src_out   <= src_d;
      if (pop_d) data_out <= (src_d == SRC_F1) ? data1 : data0;
    end
  end

endmodule

// File: tb/tb_fifo2_pop_arbiter.sv
// tb_fifo2_pop_arbiter: self-checking bench for fifo2_pop_arbiter.
// The two read FIFOs are modelled as queues; every popped word is expected
// on valid_out/data_out/src_out exactly two cycles later.
module tb_fifo2_pop_arbiter;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BURST_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              active;
  logic              empty0, empty1;
  logic [DATA_W-1:0] data0, data1;
  logic              almost_full_out;
  logic              pop0, pop1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              src_out;

  always #5 clk = ~clk;

  fifo2_pop_arbiter #(
    .DATA_W   (DATA_W),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .empty0         (empty0),
    .empty1         (empty1),
    .data0          (data0),
    .data1          (data1),
    .almost_full_out(almost_full_out),
    .pop0           (pop0),
    .pop1           (pop1),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .src_out        (src_out)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // expected output pipeline: stage = popped last cycle, exp = visible now
  logic       st_v = 1'b0, st_src = 1'b0;
  logic [7:0] st_w = '0;
  logic       exp_v = 1'b0, exp_src = 1'b0;
  logic [7:0] exp_data = '0;

  string pop_str = "";
  string out_str = "";
  int    n_valid = 0;
  int    cyc = 0;
  int    v_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_chk++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
    end
  endtask

  // One clock cycle: present FIFO flags, check strobes, advance the FIFO and
  // output models, then check the registered outputs.
  task automatic step();
    logic       p0, p1, rst_s;
    logic [7:0] w;
    empty0 = (q0.size() == 0);
    empty1 = (q1.size() == 0);
    #3;
    p0    = pop0;
    p1    = pop1;
    rst_s = reset;
    check("pop_both", p0 & p1, 0);
    check("pop0_on_empty", p0 & empty0, 0);
    check("pop1_on_empty", p1 & empty1, 0);
    check("pop_gated", (p0 | p1) & (rst_s | ~active | almost_full_out), 0);
    @(posedge clk);
    #1;
    cyc++;
    w = '0;
    if (p0 && q0.size() > 0) begin w = q0.pop_front(); data0 = w; end
    else data0 = 8'($urandom);
    if (p1 && q1.size() > 0) begin w = q1.pop_front(); data1 = w; end
    else data1 = 8'($urandom);
    if (p0 | p1) pop_str = $sformatf("%s%0d", pop_str, p1);
    if (rst_s) begin
      exp_v = 1'b0; exp_data = '0; exp_src = 1'b0; st_v = 1'b0;
    end else begin
      exp_v = st_v;
      if (st_v) begin exp_data = st_w; exp_src = st_src; end
      st_v = p0 | p1; st_w = w; st_src = p1;
    end
    check("valid_out", valid_out, exp_v);
    check("data_out", data_out, exp_data);
    if (exp_v) check("src_out", src_out, exp_src);
    if (valid_out) begin
      n_valid++;
      v_cyc.push_back(cyc);
      out_str = $sformatf("%s%02x/%0d ", out_str, data_out, src_out);
    end
  endtask

  task automatic fill(input int n0, input int n1);
    for (int i = 0; i < n0; i++) q0.push_back(8'(8'h10 + i));
    for (int i = 0; i < n1; i++) q1.push_back(8'(8'h80 + i));
  endtask

  task automatic start_test();
    q0.delete(); q1.delete();
    reset = 1'b1; active = 1'b1; almost_full_out = 1'b0;
    repeat (2) step();
    pop_str = ""; out_str = ""; n_valid = 0; v_cyc.delete();
  endtask

  initial begin
    reset = 1'b1; active = 1'b0; almost_full_out = 1'b0;
    data0 = '0; data1 = '0; empty0 = 1'b1; empty1 = 1'b1;

    // T1: long reset with both FIFOs loaded, then first grant goes to FIFO 0
    fill(2, 2);
    active = 1'b1;
    repeat (6) step();
    check_str("reset_no_pop", pop_str, "");
    check("reset_valid_cnt", n_valid, 0);
    check("reset_data_out", data_out, 0);
    check("reset_src_out", src_out, 0);
    reset = 1'b0;
    step();
    check_str("idle_to_pop_latency", pop_str, "");
    step();
    check_str("first_pop_f0", pop_str, "0");
    repeat (12) step();

    // T2: mixed loads, bursts of BURST_MAX
    start_test();
    q0.push_back(8'hFF); q0.push_back(8'hDD); q0.push_back(8'hEE);
    q0.push_back(8'hCC); q0.push_back(8'h99);
    q1.push_back(8'hAA); q1.push_back(8'h88);
    reset = 1'b0;
    repeat (16) step();
`ifdef FIFO2_ARB_STRICT_PRIO_EN
    check_str("t2_sequence", out_str, "ff/0 dd/0 ee/0 cc/0 99/0 aa/1 88/1 ");
    check("t2_no_gap", (v_cyc.size() > 4) ? (v_cyc[4] - v_cyc[0]) : -1, 4);
`else
    check_str("t2_sequence", out_str, "ff/0 dd/0 ee/0 cc/0 aa/1 88/1 99/0 ");
    check("t2_no_gap", (v_cyc.size() > 5) ? (v_cyc[5] - v_cyc[0]) : -1, 5);
`endif

    // T3: FIFO 0 only, three words
    start_test();
    fill(3, 0);
    reset = 1'b0;
    repeat (10) step();
    check_str("t3_pops", pop_str, "000");
    check("t3_valid_cnt", n_valid, 3);

    // T4: almost-full stall mid-burst
    start_test();
    fill(6, 2);
    reset = 1'b0;
    repeat (3) step();
    check_str("t4_before_stall", pop_str, "00");
    almost_full_out = 1'b1;
    repeat (5) step();
    check_str("t4_during_stall", pop_str, "00");
    almost_full_out = 1'b0;
    repeat (15) step();
`ifdef FIFO2_ARB_STRICT_PRIO_EN
    check_str("t4_trace", pop_str, "00000011");
`else
    check_str("t4_trace", pop_str, "00001100");
`endif
    check("t4_valid_cnt", n_valid, 8);

    // T5: active dropped with two words in flight
    start_test();
    fill(6, 3);
    reset = 1'b0;
    repeat (3) step();
    active = 1'b0;
    repeat (4) step();
    check_str("t5_inactive_pops", pop_str, "00");
    check("t5_inflight_out", n_valid, 2);
    active = 1'b1;
    repeat (20) step();
    check_str("t5_trace", pop_str, "000000111");
    check("t5_valid_cnt", n_valid, 9);

    // T6: both FIFOs loaded with six words
    start_test();
    fill(6, 6);
    reset = 1'b0;
    repeat (25) step();
`ifdef FIFO2_ARB_STRICT_PRIO_EN
    check_str("t6_trace", pop_str, "000000111111");
`else
    check_str("t6_trace", pop_str, "000011110011");
`endif
    check("t6_valid_cnt", n_valid, 12);

    // Random traffic with stalls, lock loss and occasional resets
    start_test();
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 4 && q0.size() < 8) q0.push_back(8'($urandom));
      if ($urandom_range(0, 9) < 4 && q1.size() < 8) q1.push_back(8'($urandom));
      active          = ($urandom_range(0, 9) != 0);
      almost_full_out = ($urandom_range(0, 5) == 0);
      reset           = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; active = 1'b1; almost_full_out = 1'b0;
    repeat (40) step();
    check("rand_drain_q0", q0.size(), 0);
    check("rand_drain_q1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
